// File: rtl/dac_serial_pkg.sv
// Shared definitions for the multi-channel DAC serializer: FSM encoding and
// elaboration-time width helpers.
package dac_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int pad_w(input int frame_w, input int mode_w, input int data_w);
    return frame_w - mode_w - data_w;
  endfunction

  // Width able to hold v-1; never below one bit so degenerate counters still elaborate.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dac_shift_lane.sv
// One channel's frame shift register. The head bit is a flop output so the
// serial line never glitches; LSB-first order is handled by reversing on load.
module dac_shift_lane #(
  parameter int FRAME_W   = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_bit
);

  logic [FRAME_W-1:0] r_sreg;
  logic [FRAME_W-1:0] w_load_val;

  always_comb begin
    w_load_val = i_frame;
    if (!MSB_FIRST) begin
      for (int i = 0; i < FRAME_W; i++) w_load_val[i] = i_frame[FRAME_W-1-i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_sreg <= '0;
    else if (i_load)  r_sreg <= w_load_val;
    else if (i_shift) r_sreg <= r_sreg << 1;
  end

  assign o_bit = r_sreg[FRAME_W-1];

endmodule

// File: rtl/dac_serial_tx.sv
// Multi-channel SPI-style DAC serializer: captures {pad, mode, data} per channel
// on a valid/ready handshake and shifts all lanes out in lockstep under one sync_n.
module dac_serial_tx
  import dac_serial_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 12,
  parameter int MODE_W    = 2,
  parameter int FRAME_W   = 16,
  parameter int GAP_CYC   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   i_sclk,
  input  logic                   i_rst,
  input  logic [N_CH*DATA_W-1:0] i_data,
  input  logic [MODE_W-1:0]      i_mode,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_sync_n,
  output logic [N_CH-1:0]        o_sdata,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int PAD_W = pad_w(FRAME_W, MODE_W, DATA_W);
  localparam int CNT_W = clog2(FRAME_W);
  localparam int GAP_W = clog2(GAP_CYC);

  if (PAD_W < 0) begin : g_bad_pad
    $error("dac_serial_tx: FRAME_W too small for MODE_W+DATA_W");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $error("dac_serial_tx: GAP_CYC must be at least 1");
  end

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_sync_n, r_done;
  logic               w_load, w_shift, w_sync_n_nxt, w_done_nxt;

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_valid) w_next = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == '0) w_next = ST_GAP;
      ST_GAP:   if (r_gap_cnt == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // sync_n and done are computed from the next state and registered, so they
  // change on the same edge as the lane head bits.
  always_comb begin
    w_load       = (r_state == ST_IDLE) && i_valid;
    w_shift      = (r_state == ST_SHIFT);
    w_sync_n_nxt = (w_next != ST_SHIFT);
    w_done_nxt   = (r_state == ST_SHIFT) && (w_next == ST_GAP);
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sync_n  <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      if (w_load)                        r_bit_cnt <= CNT_W'(FRAME_W-1);
      else if (w_shift && r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
      if (w_done_nxt)                    r_gap_cnt <= GAP_W'(GAP_CYC-1);
      else if (r_state == ST_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
      r_sync_n <= w_sync_n_nxt;
      r_done   <= w_done_nxt;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    logic [FRAME_W-1:0] w_frame;

    always_comb begin
      w_frame                    = '0;
      w_frame[DATA_W +: MODE_W]  = i_mode;
      w_frame[DATA_W-1:0]        = i_data[c*DATA_W +: DATA_W];
    end

    dac_shift_lane #(
      .FRAME_W   (FRAME_W),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .i_clk   (i_sclk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_frame (w_frame),
      .o_bit   (o_sdata[c])
    );
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_busy   = (r_state == ST_SHIFT) || (r_state == ST_GAP);
  assign o_sync_n = r_sync_n;
  assign o_done   = r_done;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: a default MSB-first instance and an LSB-first,
// three-cycle-gap instance, checked against a per-cycle frame timeline model.
module tb_dac_serial_tx;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;
  localparam int MODE_W  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2*DATA_W-1:0] data0, data1;
  logic [MODE_W-1:0]   mode0, mode1;
  logic                valid0, valid1;
  logic                ready0, sync0, busy0, done0;
  logic                ready1, sync1, busy1, done1;
  logic [1:0]          sd0, sd1;

  dac_serial_tx #(
    .N_CH(2), .DATA_W(DATA_W), .MODE_W(MODE_W), .FRAME_W(FRAME_W),
    .GAP_CYC(1), .MSB_FIRST(1'b1)
  ) u_dut0 (
    .i_sclk(clk), .i_rst(rst), .i_data(data0), .i_mode(mode0), .i_valid(valid0),
    .o_ready(ready0), .o_sync_n(sync0), .o_sdata(sd0), .o_busy(busy0), .o_done(done0)
  );

  dac_serial_tx #(
    .N_CH(2), .DATA_W(DATA_W), .MODE_W(MODE_W), .FRAME_W(FRAME_W),
    .GAP_CYC(3), .MSB_FIRST(1'b0)
  ) u_dut1 (
    .i_sclk(clk), .i_rst(rst), .i_data(data1), .i_mode(mode1), .i_valid(valid1),
    .o_ready(ready1), .o_sync_n(sync1), .o_sdata(sd1), .o_busy(busy1), .o_done(done1)
  );

  int checks = 0;
  int failures = 0;

  logic       os   [0:63];
  logic [1:0] osd  [0:63];
  logic       od   [0:63];
  logic       ordy [0:63];
  logic       obsy [0:63];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      os[i]   = sel ? sync1  : sync0;
      osd[i]  = sel ? sd1    : sd0;
      od[i]   = sel ? done1  : done0;
      ordy[i] = sel ? ready1 : ready0;
      obsy[i] = sel ? busy1  : busy0;
      tick();
    end
  endtask

  // Frame word as the DAC sees it: mode sits directly above the data, pad is zero.
  function automatic logic [FRAME_W-1:0] model_frame(input logic [MODE_W-1:0] m,
                                                     input logic [DATA_W-1:0] d);
    return FRAME_W'((int'(m) << DATA_W) + int'(d));
  endfunction

  function automatic logic model_bit(input logic [FRAME_W-1:0] f, input int j, input bit msb);
    return msb ? f[FRAME_W-1-j] : f[j];
  endfunction

  // Expected {ready,busy,done,sync_n,sdata[1:0]} p cycles after the accepting edge.
  function automatic logic [5:0] model_cycle(input logic [2*DATA_W-1:0] d, input logic [MODE_W-1:0] m,
                                             input int p, input int g, input bit msb);
    logic [FRAME_W-1:0] f0, f1;
    f0 = model_frame(m, d[DATA_W-1:0]);
    f1 = model_frame(m, d[2*DATA_W-1:DATA_W]);
    if (p < FRAME_W)
      return {1'b0, 1'b1, 1'b0, 1'b0, model_bit(f1, p, msb), model_bit(f0, p, msb)};
    else if (p < FRAME_W + g)
      return {1'b0, 1'b1, (p == FRAME_W), 1'b1, 2'b00};
    else
      return {1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
  endfunction

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1; valid0 = 0; valid1 = 0; data0 = '0; data1 = '0; mode0 = '0; mode1 = '0;
    #2;
    got = {ready0, busy0, done0, sync0, sd0};
    checks++;
    if (got !== 6'b100100) begin failures++; $display("FAIL reset0 got=%b exp=100100", got); end
    got = {ready1, busy1, done1, sync1, sd1};
    checks++;
    if (got !== 6'b100100) begin failures++; $display("FAIL reset1 got=%b exp=100100", got); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [5:0] got, exp;
    logic [15:0] w0, w1;
    data0 = {12'h123, 12'hABC}; mode0 = 2'b00; valid0 = 1;
    tick(); valid0 = 0;
    capture(0, 19);
    for (int t = 0; t < 19; t++) begin
      exp = model_cycle({12'h123, 12'hABC}, 2'b00, t, 1, 1'b1);
      got = {ordy[t], obsy[t], od[t], os[t], osd[t]};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL basic t=%0d got=%b exp=%b", t, got, exp); end
    end
    w0 = '0; w1 = '0;
    for (int j = 0; j < 16; j++) begin w0 = {w0[14:0], osd[j][0]}; w1 = {w1[14:0], osd[j][1]}; end
    checks++;
    if (w0 !== 16'h0ABC) begin failures++; $display("FAIL basic_word0 got=%h exp=0abc", w0); end
    checks++;
    if (w1 !== 16'h0123) begin failures++; $display("FAIL basic_word1 got=%h exp=0123", w1); end
  endtask

  task automatic test_mode();
    logic [15:0] w0;
    data0 = {12'($urandom), 12'h000}; mode0 = 2'b11; valid0 = 1;
    tick(); valid0 = 0;
    capture(0, 18);
    w0 = '0;
    for (int j = 0; j < 16; j++) w0 = {w0[14:0], osd[j][0]};
    checks++;
    if (w0 !== 16'h3000) begin failures++; $display("FAIL mode_word got=%h exp=3000", w0); end
  endtask

  task automatic test_random();
    logic [5:0] got, exp;
    logic [2*DATA_W-1:0] d;
    logic [MODE_W-1:0] m;
    for (int n = 0; n < 4; n++) begin
      d = 24'($urandom); m = 2'($urandom);
      data0 = d; mode0 = m; valid0 = 1;
      tick(); valid0 = 0; data0 = 24'($urandom); mode0 = 2'($urandom);
      capture(0, 18);
      for (int t = 0; t < 18; t++) begin
        exp = model_cycle(d, m, t, 1, 1'b1);
        got = {ordy[t], obsy[t], od[t], os[t], osd[t]};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL random n=%0d t=%0d got=%b exp=%b", n, t, got, exp); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DATA_W-1:0] d [0:2];
    logic [MODE_W-1:0] m;
    logic [5:0] got, exp;
    int dn, base;
    dn = 0;
    for (int f = 0; f < 3; f++) d[f] = 24'($urandom);
    m = 2'($urandom);
    data0 = d[0]; mode0 = m; valid0 = 1;
    tick();
    for (int t = 0; t < 60; t++) begin
      if (t == 0)  data0 = d[1];
      if (t == 18) data0 = d[2];
      if (t == 36) begin valid0 = 0; data0 = 24'($urandom); end
      base = (t < 36) ? 18 * (t / 18) : 36;
      exp = model_cycle(d[base/18], m, t - base, 1, 1'b1);
      got = {ready0, busy0, done0, sync0, sd0};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b t=%0d got=%b exp=%b", t, got, exp); end
      if (done0) dn++;
      tick();
    end
    checks++;
    if (dn !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dn); end
  endtask

  task automatic test_ignore();
    logic [2*DATA_W-1:0] d;
    logic [MODE_W-1:0] m;
    logic [5:0] got, exp;
    d = 24'($urandom); m = 2'($urandom);
    data0 = d; mode0 = m; valid0 = 1;
    tick(); valid0 = 0;
    for (int t = 0; t < 40; t++) begin
      if (t == 5) begin data0 = 24'($urandom); mode0 = 2'($urandom); end
      if (t == 5 || t == 10 || t == 16) valid0 = 1;
      if (t == 6 || t == 11 || t == 17) valid0 = 0;
      exp = model_cycle(d, m, t, 1, 1'b1);
      got = {ready0, busy0, done0, sync0, sd0};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL ignore t=%0d got=%b exp=%b", t, got, exp); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [2*DATA_W-1:0] d;
    logic [MODE_W-1:0] m;
    logic [5:0] got, exp;
    d = 24'($urandom); m = 2'($urandom);
    data0 = d; mode0 = m; valid0 = 1;
    tick(); valid0 = 0;
    capture(0, 8);
    for (int t = 0; t < 8; t++) begin
      exp = model_cycle(d, m, t, 1, 1'b1);
      got = {ordy[t], obsy[t], od[t], os[t], osd[t]};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rstmid_pre t=%0d got=%b exp=%b", t, got, exp); end
    end
    rst = 1'b1;
    #2;
    got = {ready0, busy0, done0, sync0, sd0};
    checks++;
    if (got !== 6'b100100) begin failures++; $display("FAIL rstmid_async got=%b exp=100100", got); end
    tick(); rst = 1'b0; tick(); tick();
    got = {ready0, busy0, done0, sync0, sd0};
    checks++;
    if (got !== 6'b100100) begin failures++; $display("FAIL rstmid_noresume got=%b exp=100100", got); end
    d = 24'($urandom); m = 2'($urandom);
    data0 = d; mode0 = m; valid0 = 1;
    tick(); valid0 = 0;
    capture(0, 18);
    for (int t = 0; t < 18; t++) begin
      exp = model_cycle(d, m, t, 1, 1'b1);
      got = {ordy[t], obsy[t], od[t], os[t], osd[t]};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL rstmid_post t=%0d got=%b exp=%b", t, got, exp); end
    end
  endtask

  task automatic test_lsb_gap();
    logic [2*DATA_W-1:0] d;
    logic [MODE_W-1:0] m;
    logic [5:0] got, exp;
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? {12'($urandom), 12'h001} : 24'($urandom);
      m = (n == 0) ? 2'b00 : 2'($urandom);
      data1 = d; mode1 = m; valid1 = 1;
      tick(); valid1 = 0;
      capture(1, 24);
      for (int t = 0; t < 24; t++) begin
        exp = model_cycle(d, m, t, 3, 1'b0);
        got = {ordy[t], obsy[t], od[t], os[t], osd[t]};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL lsb n=%0d t=%0d got=%b exp=%b", n, t, got, exp); end
      end
      if (n == 0) begin
        checks++;
        if (osd[0][0] !== 1'b1 || osd[1][0] !== 1'b0 || osd[15][0] !== 1'b0) begin
          failures++; $display("FAIL lsb_first_bit got=%b%b%b exp=100", osd[0][0], osd[1][0], osd[15][0]);
        end
        checks++;
        if (ordy[18] !== 1'b0 || ordy[19] !== 1'b1) begin
          failures++; $display("FAIL lsb_ready got=%b%b exp=01", ordy[18], ordy[19]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode();
    test_random();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_lsb_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
